// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//   Lets the IFU and the LSU share one memory port. Only one transaction is in flight at a time.
//   The arbiter accepts a request, sends it to memory, captures the reply and hands the reply
//   back to the requester that was granted. The LSU normally has priority. The IFU is forced
//   to win once it has lost STARVE_MAX LSU grants in a row while it was waiting.
//
// Ports
//   clk, rst                      clock (rising edge); synchronous active-high reset
//   ifu_req_valid/ready/addr      IFU fetch request (read only)
//   ifu_rsp_valid/ready/rdata     IFU response
//   lsu_req_valid/ready/addr/wen/wdata/wmask   LSU load/store request
//   lsu_rsp_valid/ready/rdata     LSU response (rdata is 0 for stores)
//   mem_req_valid/ready/addr/wen/wdata/wmask   request to memory, fields held while pending
//   mem_rsp_valid/rdata           memory reply pulse (no back-pressure)
//   proto_err                     sticky; memory replied when no reply was expected

module core_mem_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MASK_W     = XLEN / 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [XLEN-1:0]   ifu_req_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [XLEN-1:0]   ifu_rsp_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [XLEN-1:0]   lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [XLEN-1:0]   lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [XLEN-1:0]   lsu_rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              proto_err
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_ifu_q, owner_ifu_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [3:0]        starve_q, starve_d;
  logic              proto_err_q, proto_err_d;

  logic ifu_starved, lsu_win, ifu_win;

  // The LSU wins unless the IFU is waiting and has already lost STARVE_MAX grants in a row.
  assign ifu_starved = ifu_req_valid && (starve_q == StarveMax);
  assign lsu_win     = lsu_req_valid && !ifu_starved;
  assign ifu_win     = ifu_req_valid && !lsu_win;

  always_comb begin
    state_d       = state_q;
    owner_ifu_d   = owner_ifu_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
    starve_d      = starve_q;
    proto_err_d   = proto_err_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_rdata = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_rdata = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;

    unique case (state_q)
      StIdle: begin
        // Readies are held low while reset is asserted, so no handshake is seen during reset.
        lsu_req_ready = !rst && lsu_win;
        ifu_req_ready = !rst && ifu_win;
        if (lsu_req_ready) begin
          owner_ifu_d = 1'b0;
          addr_d      = lsu_req_addr;
          wen_d       = lsu_req_wen;
          wdata_d     = lsu_req_wdata;
          wmask_d     = lsu_req_wmask;
          if (ifu_req_valid && (starve_q != StarveMax)) begin
            starve_d = starve_q + 4'd1;
          end
          state_d = StIssue;
        end else if (ifu_req_ready) begin
          owner_ifu_d = 1'b1;
          addr_d      = ifu_req_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          wmask_d     = '0;
          starve_d    = 4'd0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_wen   = wen_q;
        mem_req_wdata = wdata_q;
        mem_req_wmask = wmask_q;
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rsp_valid) begin
          // Stores return 0 regardless of what memory drives.
          rdata_d = wen_q ? '0 : mem_rsp_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        if (owner_ifu_q) begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp_rdata = rdata_q;
          if (ifu_rsp_ready) begin
            state_d = StIdle;
          end
        end else begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp_rdata = rdata_q;
          if (lsu_rsp_ready) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (mem_rsp_valid && (state_q != StWait)) begin
      proto_err_d = 1'b1;
    end
  end

  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_ifu_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata_q     <= '0;
      starve_q    <= 4'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_ifu_q <= owner_ifu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MASK_W     = 4;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifu_req_valid, ifu_req_ready;
  logic [XLEN-1:0]   ifu_req_addr;
  logic              ifu_rsp_valid, ifu_rsp_ready;
  logic [XLEN-1:0]   ifu_rsp_rdata;
  logic              lsu_req_valid, lsu_req_ready;
  logic [XLEN-1:0]   lsu_req_addr;
  logic              lsu_req_wen;
  logic [XLEN-1:0]   lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_rsp_valid, lsu_rsp_ready;
  logic [XLEN-1:0]   lsu_rsp_rdata;
  logic              mem_req_valid, mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_req_wen;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;
  logic              proto_err;

  always #5 clk = ~clk;

  core_mem_arbiter #(
    .XLEN      (XLEN),
    .MASK_W    (MASK_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr (ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr (lsu_req_addr),
    .lsu_req_wen  (lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_wen  (mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .proto_err    (proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding request and where it currently sits.
  // 0: nothing outstanding, 1: offered to memory, 2: memory owes a reply, 3: reply offered.
  int                m_stage = 0;
  bit                m_ifu;
  logic [XLEN-1:0]   m_addr, m_wdata, m_rdata;
  bit                m_wen;
  logic [MASK_W-1:0] m_wmask;
  int unsigned       m_starve = 0;
  bit                m_proto = 1'b0;

  // Grants observed on the DUT ports: 1 = LSU, 2 = IFU.
  int                dut_grants[$];

  // Snapshot of the outputs from the most recent step.
  logic              s_ifu_rdy, s_lsu_rdy, s_ifu_rsp_v, s_lsu_rsp_v, s_mem_v, s_proto;
  logic [XLEN-1:0]   s_lsu_rsp_d, s_mem_addr, s_mem_wdata;
  logic [MASK_W-1:0] s_mem_wmask;

  // Inputs are set by the caller just after a falling edge; one clock cycle is checked/advanced.
  task automatic step();
    bit lsu_w, ifu_w, e_ifu_rsp, e_lsu_rsp;
    #1;
    s_ifu_rdy   = ifu_req_ready;
    s_lsu_rdy   = lsu_req_ready;
    s_ifu_rsp_v = ifu_rsp_valid;
    s_lsu_rsp_v = lsu_rsp_valid;
    s_lsu_rsp_d = lsu_rsp_rdata;
    s_mem_v     = mem_req_valid;
    s_mem_addr  = mem_req_addr;
    s_mem_wdata = mem_req_wdata;
    s_mem_wmask = mem_req_wmask;
    s_proto     = proto_err;
    if (rst) begin
      check_val("rst_ifu_req_ready", ifu_req_ready, 0);
      check_val("rst_lsu_req_ready", lsu_req_ready, 0);
      m_stage  = 0;
      m_starve = 0;
      m_proto  = 1'b0;
    end else begin
      if (lsu_req_valid && lsu_req_ready) dut_grants.push_back(1);
      if (ifu_req_valid && ifu_req_ready) dut_grants.push_back(2);
      lsu_w = lsu_req_valid && !(ifu_req_valid && m_starve == STARVE_MAX);
      ifu_w = ifu_req_valid && !lsu_w;
      check_val("ifu_req_ready", ifu_req_ready, (m_stage == 0) && ifu_w);
      check_val("lsu_req_ready", lsu_req_ready, (m_stage == 0) && lsu_w);
      check_val("mem_req_valid", mem_req_valid, m_stage == 1);
      check_val("mem_req_addr", mem_req_addr, (m_stage == 1) ? m_addr : 32'd0);
      check_val("mem_req_wen", mem_req_wen, (m_stage == 1) && m_wen);
      check_val("mem_req_wdata", mem_req_wdata, (m_stage == 1) ? m_wdata : 32'd0);
      check_val("mem_req_wmask", mem_req_wmask, (m_stage == 1) ? m_wmask : 4'd0);
      e_ifu_rsp = (m_stage == 3) && m_ifu;
      e_lsu_rsp = (m_stage == 3) && !m_ifu;
      check_val("ifu_rsp_valid", ifu_rsp_valid, e_ifu_rsp);
      check_val("lsu_rsp_valid", lsu_rsp_valid, e_lsu_rsp);
      if (e_ifu_rsp) check_val("ifu_rsp_rdata", ifu_rsp_rdata, m_rdata);
      if (e_lsu_rsp) check_val("lsu_rsp_rdata", lsu_rsp_rdata, m_rdata);
      check_val("proto_err", proto_err, m_proto);

      if (mem_rsp_valid && m_stage != 2) m_proto = 1'b1;
      case (m_stage)
        0: begin
          if (lsu_w) begin
            m_ifu   = 1'b0;
            m_addr  = lsu_req_addr;
            m_wen   = lsu_req_wen;
            m_wdata = lsu_req_wdata;
            m_wmask = lsu_req_wmask;
            if (ifu_req_valid && m_starve < STARVE_MAX) m_starve++;
            m_stage = 1;
          end else if (ifu_w) begin
            m_ifu    = 1'b1;
            m_addr   = ifu_req_addr;
            m_wen    = 1'b0;
            m_wdata  = '0;
            m_wmask  = '0;
            m_starve = 0;
            m_stage  = 1;
          end
        end
        1: if (mem_req_ready) m_stage = 2;
        2: begin
          if (mem_rsp_valid) begin
            m_rdata = m_wen ? '0 : mem_rsp_rdata;
            m_stage = 3;
          end
        end
        3: if (m_ifu ? ifu_rsp_ready : lsu_rsp_ready) m_stage = 0;
        default: m_stage = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wen   = 1'b0;
    lsu_req_wdata = '0;
    lsu_req_wmask = '0;
    lsu_rsp_ready = 1'b1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int k = 0; k < 20 && m_stage != 0; k++) begin
      mem_rsp_valid = (m_stage == 2);
      mem_rsp_rdata = $urandom;
      step();
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic rand_inputs();
    ifu_req_valid = ($urandom_range(0, 3) != 0);
    ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
    lsu_req_valid = ($urandom_range(0, 2) != 0);
    lsu_req_addr  = $urandom;
    lsu_req_wen   = 1'($urandom_range(0, 1));
    lsu_req_wdata = $urandom;
    lsu_req_wmask = 4'($urandom);
    ifu_rsp_ready = ($urandom_range(0, 3) != 0);
    lsu_rsp_ready = ($urandom_range(0, 3) != 0);
    mem_req_ready = 1'($urandom_range(0, 1));
    mem_rsp_valid = (m_stage == 2) && ($urandom_range(0, 1) == 1);
    mem_rsp_rdata = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    bit          seen;
    logic [31:0] rd;
    int          exp_order[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    // Reset with every valid high.
    idle_inputs();
    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    repeat (2) step();
    rst = 1'b0;
    idle_inputs();
    step();
    check_val("t1_outputs_after_rst",
              {s_mem_v, s_ifu_rsp_v, s_lsu_rsp_v, s_proto, s_ifu_rdy, s_lsu_rdy}, 0);

    // Minimum-latency LSU load.
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h8000_0010;
    lsu_req_wen   = 1'b0;
    mem_rsp_rdata = 32'hDEAD_BEEF;
    step();
    check_val("t2_lsu_grant", s_lsu_rdy, 1);
    lsu_req_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    rd   = '0;
    for (int k = 1; k <= 8; k++) begin
      mem_rsp_valid = (m_stage == 2);
      step();
      if (s_ifu_rsp_v) seen = 1'b1;
      if (s_lsu_rsp_v && lat == 0) begin
        lat = k;
        rd  = s_lsu_rsp_d;
      end
    end
    check_val("t2_rsp_latency", lat, 3);
    check_val("t2_rsp_rdata", rd, 32'hDEAD_BEEF);
    check_val("t2_ifu_rsp_seen", seen, 0);

    // Both requesters continuously active: anti-starvation pattern.
    dut_grants.delete();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h40;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h200;
    for (int k = 0; k < 80 && dut_grants.size() < 10; k++) begin
      mem_rsp_valid = (m_stage == 2);
      mem_rsp_rdata = $urandom;
      step();
    end
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("t3_grant%0d", i), (i < dut_grants.size()) ? dut_grants[i] : 0,
                exp_order[i]);
    end
    drain();

    // Store with memory back-pressure: fields stay put, response data is 0.
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h100;
    lsu_req_wen   = 1'b1;
    lsu_req_wdata = 32'h1122_3344;
    lsu_req_wmask = 4'b0011;
    mem_req_ready = 1'b0;
    step();
    lsu_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("t4_hold_valid", s_mem_v, 1);
      check_val("t4_hold_addr", s_mem_addr, 32'h100);
      check_val("t4_hold_wdata", s_mem_wdata, 32'h1122_3344);
      check_val("t4_hold_wmask", s_mem_wmask, 4'b0011);
    end
    mem_req_ready = 1'b1;
    mem_rsp_rdata = 32'hFFFF_FFFF;
    seen = 1'b0;
    rd   = 32'hFFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      mem_rsp_valid = (m_stage == 2);
      step();
      if (s_lsu_rsp_v && !seen) begin
        seen = 1'b1;
        rd   = s_lsu_rsp_d;
      end
    end
    check_val("t4_rsp_seen", seen, 1);
    check_val("t4_store_rdata", rd, 0);

    // Response back-pressure blocks new grants.
    idle_inputs();
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h300;
    lsu_rsp_ready = 1'b0;
    mem_rsp_rdata = 32'h5A5A_1234;
    step();
    lsu_req_valid = 1'b0;
    for (int k = 0; k < 10 && m_stage != 3; k++) begin
      mem_rsp_valid = (m_stage == 2);
      step();
    end
    mem_rsp_valid = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("t5_hold_valid", s_lsu_rsp_v, 1);
      check_val("t5_hold_rdata", s_lsu_rsp_d, 32'h5A5A_1234);
      check_val("t5_no_ifu_grant", s_ifu_rdy, 0);
      check_val("t5_no_lsu_grant", s_lsu_rdy, 0);
    end
    lsu_rsp_ready = 1'b1;
    step();
    check_val("t5_hs_no_grant", s_lsu_rdy, 0);
    step();
    check_val("t5_grant_after_hs", s_lsu_rdy, 1);
    drain();

    // Stray memory reply in IDLE, then reset while waiting on memory.
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    step();
    check_val("t6_proto_err", s_proto, 1);
    check_val("t6_idle_no_mem_req", s_mem_v, 0);
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h400;
    lsu_req_wen   = 1'b0;
    step();
    check_val("t6_still_idle_grant", s_lsu_rdy, 1);
    lsu_req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_lsu_rsp_v || s_ifu_rsp_v || s_mem_v) seen = 1'b1;
    end
    check_val("t6_abandoned_no_rsp", seen, 0);
    check_val("t6_proto_cleared", s_proto, 0);

    // Randomized traffic against the reference.
    repeat (4000) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
